// File: rtl/mem_arbiter_if.sv
// Memory arbiter bus bundle: Dcache/Icache requests, memory port, per-cache returns.
// Latency: n/a (signal bundle only).
// Backpressure: memory stalls by returning response 0; a requester seeing 0 must hold.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    // Dcache request side
    logic [1:0]      Dcache2mem_command;
    logic [XLEN-1:0] Dcache2mem_addr;
    logic [63:0]     Dcache2mem_data;
    // Icache request side (loads only)
    logic [1:0]      Icache2mem_command;
    logic [XLEN-1:0] Icache2mem_addr;
    // Memory response side
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;
    // Memory request side
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    // Dcache return side
    logic [3:0]      mem2Dcache_response;
    logic [63:0]     mem2Dcache_data;
    logic [3:0]      mem2Dcache_tag;
    // Icache return side
    logic [3:0]      mem2Icache_response;
    logic [63:0]     mem2Icache_data;
    logic [3:0]      mem2Icache_tag;
    // Status
    logic            grant_icache;
    logic            tag_error;

    // Arbiter side
    modport slave (
        input  Dcache2mem_command, Dcache2mem_addr, Dcache2mem_data,
        input  Icache2mem_command, Icache2mem_addr,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2Dcache_response, mem2Dcache_data, mem2Dcache_tag,
        output mem2Icache_response, mem2Icache_data, mem2Icache_tag,
        output grant_icache, tag_error
    );

    // Caches/memory side
    modport master (
        output Dcache2mem_command, Dcache2mem_addr, Dcache2mem_data,
        output Icache2mem_command, Icache2mem_addr,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2Dcache_response, mem2Dcache_data, mem2Dcache_tag,
        input  mem2Icache_response, mem2Icache_data, mem2Icache_tag,
        input  grant_icache, tag_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (Dcache priority, Icache anti-starvation) with tag ownership table.
// Latency: grant and response routing combinational (0 cycles); owner table/tag_error update at the edge.
// Backpressure: the loser sees response 0 (stall) and must hold; nothing is buffered here.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic          clock,
    input  logic          reset,   // synchronous, active-low
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;
    localparam int         SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;
    logic [15:0]   valid_q, valid_d;
    logic [15:0]   owner_q, owner_d;   // 1 = Icache, 0 = Dcache
    logic          tag_error_q, tag_error_d;

    logic          icache_req, dcache_req;
    logic          grant_i, grant_d;
    logic [1:0]    fwd_cmd;
    logic [3:0]    resp, cpl_tag;
    logic          cpl_hit, accept_load;

    // Grant selection and forwarding of the winner onto the memory port
    always_comb begin
        icache_req = (bus.Icache2mem_command != BUS_NONE);
        dcache_req = (bus.Dcache2mem_command != BUS_NONE);
        grant_i    = reset && icache_req && (!dcache_req || (starve_q >= LIMIT));
        grant_d    = reset && dcache_req && !grant_i;
        resp       = bus.mem2proc_response;

        fwd_cmd            = BUS_NONE;
        bus.proc2mem_addr  = '0;
        bus.proc2mem_data  = '0;
        if (grant_i) begin
            fwd_cmd           = bus.Icache2mem_command;
            bus.proc2mem_addr = bus.Icache2mem_addr;
        end else if (grant_d) begin
            fwd_cmd           = bus.Dcache2mem_command;
            bus.proc2mem_addr = bus.Dcache2mem_addr;
            bus.proc2mem_data = bus.Dcache2mem_data;
        end
        bus.proc2mem_command    = fwd_cmd;
        bus.grant_icache        = grant_i;
        bus.mem2Dcache_response = grant_d ? resp : 4'd0;
        bus.mem2Icache_response = grant_i ? resp : 4'd0;
        accept_load             = (grant_i || grant_d) && (fwd_cmd == BUS_LOAD) && (resp != 4'd0);
    end

    // Completion routing: the owner table steers the tag, data goes to both caches
    always_comb begin
        cpl_tag                 = bus.mem2proc_tag;
        cpl_hit                 = reset && (cpl_tag != 4'd0) && valid_q[cpl_tag];
        bus.mem2Dcache_tag      = (cpl_hit && !owner_q[cpl_tag]) ? cpl_tag : 4'd0;
        bus.mem2Icache_tag      = (cpl_hit &&  owner_q[cpl_tag]) ? cpl_tag : 4'd0;
        bus.mem2Dcache_data     = bus.mem2proc_data;
        bus.mem2Icache_data     = bus.mem2proc_data;
        bus.tag_error           = tag_error_q;
    end

    // Next-state: completion clears before acceptance writes, so a same-tag accept wins
    always_comb begin
        valid_d     = valid_q;
        owner_d     = owner_q;
        tag_error_d = tag_error_q;
        starve_d    = starve_q;
        if (cpl_tag != 4'd0) begin
            if (valid_q[cpl_tag]) begin
                valid_d[cpl_tag] = 1'b0;
            end else begin
                tag_error_d = 1'b1;
            end
        end
        if (accept_load) begin
            valid_d[resp] = 1'b1;
            owner_d[resp] = grant_i;
        end
        if (!icache_req || (grant_i && (resp != 4'd0))) begin
            starve_d = '0;
        end else if (starve_q < LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_q    <= '0;
            valid_q     <= '0;
            owner_q     <= '0;
            tag_error_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            valid_q     <= valid_d;
            owner_q     <= owner_d;
            tag_error_q <= tag_error_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
// Latency: outputs compared mid-cycle after each input change; model state advances at each edge.
// Backpressure: memory stalls are modelled by random response 0.
module tb_mem_arbiter;
    localparam int LIM = 4;

    logic clock = 1'b0;
    logic reset;
    mem_arbiter_if #(.XLEN(32)) bus ();

    mem_arbiter #(.STARVE_LIMIT(LIM), .XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who owns each outstanding tag (-1 none, 0 Dcache, 1 Icache)
    int m_own[16];
    int m_starve;
    bit m_err;
    bit e_gi, e_gd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                         input logic [1:0] ic, input logic [31:0] ia, input logic [3:0] rsp,
                         input logic [63:0] md, input logic [3:0] tg);
        reset                  = rst;
        bus.Dcache2mem_command = dc;
        bus.Dcache2mem_addr    = da;
        bus.Dcache2mem_data    = dd;
        bus.Icache2mem_command = ic;
        bus.Icache2mem_addr    = ia;
        bus.mem2proc_response  = rsp;
        bus.mem2proc_data      = md;
        bus.mem2proc_tag       = tg;
    endtask

    // Compare every output against what the rules say for the current inputs
    task automatic compare();
        bit ireq, dreq;
        int o;
        logic [3:0] t;
        logic [1:0] ec;
        logic [31:0] ea;
        logic [63:0] ed;
        ireq = (bus.Icache2mem_command != 2'd0);
        dreq = (bus.Dcache2mem_command != 2'd0);
        e_gi = reset && ireq && (!dreq || m_starve >= LIM);
        e_gd = reset && dreq && !e_gi;
        ec = 2'd0; ea = 32'd0; ed = 64'd0;
        if (e_gi) begin ec = bus.Icache2mem_command; ea = bus.Icache2mem_addr; end
        if (e_gd) begin ec = bus.Dcache2mem_command; ea = bus.Dcache2mem_addr; ed = bus.Dcache2mem_data; end
        t = bus.mem2proc_tag;
        o = (reset && t != 4'd0) ? m_own[t] : -1;
        chk("cmd",    64'(bus.proc2mem_command), 64'(ec));
        chk("addr",   64'(bus.proc2mem_addr), 64'(ea));
        chk("wdata",  bus.proc2mem_data, ed);
        chk("d_resp", 64'(bus.mem2Dcache_response), e_gd ? 64'(bus.mem2proc_response) : 64'd0);
        chk("i_resp", 64'(bus.mem2Icache_response), e_gi ? 64'(bus.mem2proc_response) : 64'd0);
        chk("d_tag",  64'(bus.mem2Dcache_tag), (o == 0) ? 64'(t) : 64'd0);
        chk("i_tag",  64'(bus.mem2Icache_tag), (o == 1) ? 64'(t) : 64'd0);
        chk("d_data", bus.mem2Dcache_data, bus.mem2proc_data);
        chk("i_data", bus.mem2Icache_data, bus.mem2proc_data);
        chk("grant_i", 64'(bus.grant_icache), 64'(e_gi));
        chk("tag_err", 64'(bus.tag_error), 64'(m_err));
    endtask

    // Apply the edge to the model, then move to just after the next rising edge
    task automatic advance();
        logic [3:0] t, r;
        logic [1:0] gc;
        t = bus.mem2proc_tag;
        r = bus.mem2proc_response;
        gc = e_gi ? bus.Icache2mem_command : (e_gd ? bus.Dcache2mem_command : 2'd0);
        if (!reset) begin
            for (int i = 0; i < 16; i++) m_own[i] = -1;
            m_starve = 0;
            m_err = 0;
        end else begin
            if (t != 4'd0) begin
                if (m_own[t] >= 0) m_own[t] = -1;
                else m_err = 1;
            end
            if (gc == 2'd1 && r != 4'd0) m_own[r] = e_gi ? 1 : 0;
            if (bus.Icache2mem_command == 2'd0 || (e_gi && r != 4'd0)) m_starve = 0;
            else if (m_starve < LIM) m_starve++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step(input bit rst, input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                        input logic [1:0] ic, input logic [31:0] ia, input logic [3:0] rsp,
                        input logic [63:0] md, input logic [3:0] tg);
        drive(rst, dc, da, dd, ic, ia, rsp, md, tg);
        @(negedge clock);
        compare();
    endtask

    task automatic idle(input bit rst);
        step(rst, 2'd0, 32'd0, 64'd0, 2'd0, 32'd0, 4'd0, 64'd0, 4'd0);
        advance();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_own[i] = -1;
        m_starve = 0;
        m_err = 0;

        // Reset holds outputs quiet even with live requests
        step(1'b0, 2'd1, 32'h100, 64'h1, 2'd1, 32'h200, 4'd3, 64'd0, 4'd5);
        chk("rst_cmd",   64'(bus.proc2mem_command), 64'd0);
        chk("rst_dresp", 64'(bus.mem2Dcache_response), 64'd0);
        chk("rst_grant", 64'(bus.grant_icache), 64'd0);
        chk("rst_itag",  64'(bus.mem2Icache_tag), 64'd0);
        advance();
        idle(1'b0);

        // Dcache wins a simultaneous request
        step(1'b1, 2'd1, 32'h100, 64'hAA, 2'd1, 32'h200, 4'd3, 64'd0, 4'd0);
        chk("pri_addr",  64'(bus.proc2mem_addr), 64'h100);
        chk("pri_dresp", 64'(bus.mem2Dcache_response), 64'd3);
        chk("pri_iresp", 64'(bus.mem2Icache_response), 64'd0);
        advance();

        // Lone Icache load, then completion routing and entry clear
        step(1'b1, 2'd0, 32'h0, 64'h0, 2'd1, 32'h40, 4'd5, 64'd0, 4'd0);
        chk("ic_grant", 64'(bus.grant_icache), 64'd1);
        chk("ic_addr",  64'(bus.proc2mem_addr), 64'h40);
        advance();
        step(1'b1, 2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 64'hDEAD_BEEF_0000_0005, 4'd5);
        chk("t5_itag", 64'(bus.mem2Icache_tag), 64'd5);
        chk("t5_dtag", 64'(bus.mem2Dcache_tag), 64'd0);
        chk("t5_idat", bus.mem2Icache_data, 64'hDEAD_BEEF_0000_0005);
        advance();
        step(1'b1, 2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 64'h0, 4'd3);
        chk("t3_dtag", 64'(bus.mem2Dcache_tag), 64'd3);
        advance();
        step(1'b1, 2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 64'h0, 4'd5);
        chk("t5_again", 64'(bus.mem2Icache_tag), 64'd0);
        advance();
        idle(1'b1);
        chk("t5_err", 64'(bus.tag_error), 64'd1);
        idle(1'b0);
        chk("err_clr", 64'(bus.tag_error), 64'd0);

        // Stores are not tracked
        step(1'b1, 2'd2, 32'h300, 64'h55, 2'd0, 32'h0, 4'd2, 64'd0, 4'd0);
        advance();
        step(1'b1, 2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 64'h0, 4'd2);
        chk("st_dtag", 64'(bus.mem2Dcache_tag), 64'd0);
        chk("st_itag", 64'(bus.mem2Icache_tag), 64'd0);
        advance();
        idle(1'b1);
        chk("st_err", 64'(bus.tag_error), 64'd1);
        idle(1'b0);

        // Starvation: Icache wins on the 5th denied cycle, then priority returns to Dcache
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 2'd1, 32'h500, 64'h0, 2'd1, 32'h600, 4'd0, 64'd0, 4'd0);
            chk("starve_deny", 64'(bus.grant_icache), 64'd0);
            advance();
        end
        step(1'b1, 2'd1, 32'h500, 64'h0, 2'd1, 32'h600, 4'd6, 64'd0, 4'd0);
        chk("starve_win", 64'(bus.grant_icache), 64'd1);
        chk("starve_addr", 64'(bus.proc2mem_addr), 64'h600);
        advance();
        step(1'b1, 2'd1, 32'h500, 64'h0, 2'd1, 32'h600, 4'd0, 64'd0, 4'd0);
        chk("starve_clr", 64'(bus.grant_icache), 64'd0);
        advance();

        // Same-tag completion and acceptance: old owner sees it, new owner holds the entry
        step(1'b1, 2'd1, 32'h700, 64'h0, 2'd0, 32'h0, 4'd7, 64'd0, 4'd0);
        advance();
        step(1'b1, 2'd0, 32'h0, 64'h0, 2'd1, 32'h780, 4'd7, 64'd0, 4'd7);
        chk("t7_dtag", 64'(bus.mem2Dcache_tag), 64'd7);
        chk("t7_itag", 64'(bus.mem2Icache_tag), 64'd0);
        advance();
        step(1'b1, 2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 64'd0, 4'd7);
        chk("t7_new", 64'(bus.mem2Icache_tag), 64'd7);
        advance();

        // Tag issued before a reset is dropped afterwards
        step(1'b1, 2'd0, 32'h0, 64'h0, 2'd1, 32'h880, 4'd4, 64'd0, 4'd0);
        advance();
        idle(1'b0);
        step(1'b1, 2'd0, 32'h0, 64'h0, 2'd0, 32'h0, 4'd0, 64'd0, 4'd4);
        chk("rs_itag", 64'(bus.mem2Icache_tag), 64'd0);
        advance();
        idle(1'b1);
        chk("rs_err", 64'(bus.tag_error), 64'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 80) != 0),
                 2'($urandom_range(0, 2)), $urandom, {$urandom, $urandom},
                 2'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                 {$urandom, $urandom},
                 ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive denied Icache request cycles after which the Icache gets priority.
REQ-002 Tag and command widths SHALL be fixed: tag 4 bits (0 = none), command 2 bits (BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2).

Interface
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The ports SHALL be `clock` (input, 1) and `reset` (input, 1; active-low, synchronous).
REQ-005 The Dcache request ports SHALL be Dcache2mem_command (input, 2), Dcache2mem_addr (input, XLEN) and Dcache2mem_data (input, 64).
REQ-006 The Icache request ports SHALL be Icache2mem_command (input, 2) and Icache2mem_addr (input, XLEN); the Icache issues loads only.
REQ-007 The memory response inputs SHALL be mem2proc_response (4, acceptance tag), mem2proc_data (64) and mem2proc_tag (4, completion tag).
REQ-008 The memory request outputs SHALL be proc2mem_command (2), proc2mem_addr (XLEN) and proc2mem_data (64).
REQ-009 The Dcache return outputs SHALL be mem2Dcache_response (4), mem2Dcache_data (64) and mem2Dcache_tag (4).
REQ-010 The Icache return outputs SHALL be mem2Icache_response (4), mem2Icache_data (64) and mem2Icache_tag (4).
REQ-011 The status outputs SHALL be grant_icache (1; the granted requester this cycle is the Icache) and tag_error (1; sticky).

Function
REQ-012 Grant SHALL be combinational, in the same cycle as the request; at most one requester is forwarded per cycle.
REQ-013 Priority SHALL default to the Dcache; the Icache wins only if the Dcache command is BUS_NONE, or if starve_cnt >= STARVE_LIMIT.
REQ-014 starve_cnt SHALL work as follows:
- increments (saturating at STARVE_LIMIT) each cycle the Icache requests and is not granted, or is granted but the memory response is 0;
- clears to 0 when an Icache request is accepted (response != 0) or the Icache command is BUS_NONE.
REQ-015 The granted requester's command, address and data SHALL be driven on proc2mem_*; with no request, the outputs are BUS_NONE, address 0 and data 0.
REQ-016 mem2proc_response SHALL be routed only to the granted requester's *_response output; the other requester sees 0, which it treats as a stall.
REQ-017 The owner table SHALL have 16 entries, each holding {valid, owner}; it is written on the clock edge where a BUS_LOAD is accepted (response T != 0), setting entry[T] = {1, granted owner}.
REQ-018 Accepted BUS_STORE commands SHALL NOT be recorded in the owner table.
REQ-019 On mem2proc_tag = T != 0 with entry[T].valid = 1:
- T SHALL be routed to the owner's *_tag output only, and the other requester's *_tag output is 0;
- the entry SHALL be cleared at the clock edge.
REQ-020 mem2proc_data SHALL be broadcast to both *_data outputs unchanged; tag gating alone determines ownership.
REQ-021 On mem2proc_tag = T != 0 with entry[T].valid = 0, the tag SHALL be dropped (both *_tag outputs 0) and tag_error set to 1 until reset.
REQ-022 If completion tag T and acceptance tag T occur in the same cycle, the lookup SHALL use the old entry and the entry afterwards holds the new owner, valid = 1; the new write has priority over the clear.
REQ-023 Completion of one tag and acceptance of a different tag in the same cycle SHALL both update the table independently.
REQ-024 A Dcache command change while a request is ungranted SHALL be forwarded as-is; the block holds no request buffering.

Reset
REQ-025 While reset = 0, the outputs SHALL be:
- proc2mem_command = BUS_NONE;
- all *_response and *_tag outputs = 0;
- grant_icache = 0.
REQ-026 At a clock edge with reset = 0, the block SHALL clear all owner entries (valid = 0), starve_cnt = 0 and tag_error = 0.
REQ-027 Completions arriving after a mid-operation reset for tags issued before it SHALL be dropped and SHALL set tag_error.

Verification
REQ-028 Dcache LOAD 0x100 and Icache LOAD 0x200 in the same cycle, memory response 3 -> proc2mem_addr = 0x100; mem2Dcache_response = 3; mem2Icache_response = 0.
REQ-029 Icache LOAD 0x40 alone, response 5; later mem2proc_tag = 5 -> mem2Icache_tag = 5; mem2Dcache_tag = 0; entry 5 cleared.
REQ-030 Dcache requests every cycle and Icache requests continuously (STARVE_LIMIT = 4) -> the Icache is granted in the 5th cycle; starve_cnt returns to 0 after acceptance.
REQ-031 Dcache STORE accepted with tag 2, then mem2proc_tag = 2 -> both *_tag outputs 0; tag_error = 1.
REQ-032 Tag 7 completes for the Dcache while the Icache is accepted with tag 7 in the same cycle -> mem2Dcache_tag = 7 that cycle; a later tag 7 routes to the Icache.
REQ-033 Icache load outstanding (tag 4), then reset low 1 cycle, then mem2proc_tag = 4 -> dropped; tag_error = 1.
